// File: rtl/ysyx_22041405_idu_pipe.sv
// rtl/ysyx_22041405_idu_pipe.sv - registered decode stage with regfile, scoreboard and write-back port
// Optional same-cycle write-back forwarding: YSYX_22041405_IDU_WB_BYPASS_EN
module ysyx_22041405_idu_pipe #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [WIDTH-1:0]      in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_inst,
  output logic [WIDTH-1:0]      out_pc,
  output logic [WIDTH-1:0]      out_rs1_data,
  output logic [WIDTH-1:0]      out_rs2_data,
  output logic [WIDTH-1:0]      out_imm,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_rd_wen,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [WIDTH-1:0]      wb_data,
  input  logic                  flush
);
  localparam int NREG = 1 << ADDR_WIDTH;

  logic                  stage_valid_q, stage_valid_d;
  logic [31:0]           stage_inst_q, stage_inst_d;
  logic [WIDTH-1:0]      stage_pc_q, stage_pc_d;
  logic [NREG-1:0]       busy_q, busy_d;
  logic [WIDTH-1:0]      regs_q [NREG];

  logic [6:0]            opcode;
  logic [ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic                  rs1_used, rs2_used, rd_wen;
  logic [31:0]           imm32;
  logic [NREG-1:0]       wb_clr, busy_eff;
  logic                  hazard, in_fire, out_fire;

  assign opcode   = stage_inst_q[6:0];
  assign rs1      = stage_inst_q[15 +: ADDR_WIDTH];
  assign rs2      = stage_inst_q[20 +: ADDR_WIDTH];
  assign rd       = stage_inst_q[7 +: ADDR_WIDTH];
  assign rs1_used = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign rs2_used = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign rd_wen   = !(opcode inside {7'b0100011, 7'b1100011, 7'b0001111}) && (rd != '0);

  always_comb begin
    imm32 = '0;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
        imm32 = {{20{stage_inst_q[31]}}, stage_inst_q[31:20]};
      7'b0100011:
        imm32 = {{20{stage_inst_q[31]}}, stage_inst_q[31:25], stage_inst_q[11:7]};
      7'b1100011:
        imm32 = {{19{stage_inst_q[31]}}, stage_inst_q[31], stage_inst_q[7],
                 stage_inst_q[30:25], stage_inst_q[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {stage_inst_q[31:12], 12'b0};
      7'b1101111:
        imm32 = {{11{stage_inst_q[31]}}, stage_inst_q[31], stage_inst_q[19:12],
                 stage_inst_q[20], stage_inst_q[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign wb_clr = wb_en ? (NREG'(1) << wb_addr) : '0;
`ifdef YSYX_22041405_IDU_WB_BYPASS_EN
  // A write-back landing this cycle already satisfies the dependency
  assign busy_eff = busy_q & ~wb_clr;
`else
  assign busy_eff = busy_q;
`endif

  assign hazard    = stage_valid_q && ((rs1_used && busy_eff[rs1]) ||
                                       (rs2_used && busy_eff[rs2]) ||
                                       (rd_wen && busy_eff[rd]));
  assign out_valid = stage_valid_q && !hazard && !flush;
  assign out_fire  = out_valid && out_ready;
  assign in_ready  = !flush && (!stage_valid_q || out_fire);
  assign in_fire   = in_valid && in_ready;

  always_comb begin
    out_rs1_data = (rs1 == '0) ? '0 : regs_q[rs1];
    out_rs2_data = (rs2 == '0) ? '0 : regs_q[rs2];
`ifdef YSYX_22041405_IDU_WB_BYPASS_EN
    if (wb_en && wb_addr != '0 && wb_addr == rs1) out_rs1_data = wb_data;
    if (wb_en && wb_addr != '0 && wb_addr == rs2) out_rs2_data = wb_data;
`endif
  end

  assign out_inst   = stage_inst_q;
  assign out_pc     = stage_pc_q;
  assign out_imm    = WIDTH'($signed(imm32));
  assign out_rd     = rd;
  assign out_rd_wen = rd_wen;

  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_inst_d  = stage_inst_q;
    stage_pc_d    = stage_pc_q;
    if (flush) begin
      stage_valid_d = 1'b0;
    end else if (in_fire) begin
      stage_valid_d = 1'b1;
      stage_inst_d  = in_inst;
      stage_pc_d    = in_pc;
    end else if (out_fire) begin
      stage_valid_d = 1'b0;
    end
    // Clear before set so an issuing writer keeps its own bit
    busy_d = busy_q & ~wb_clr;
    if (out_fire && rd_wen) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid_q <= 1'b0;
      stage_inst_q  <= '0;
      stage_pc_q    <= '0;
      busy_q        <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_inst_q  <= stage_inst_d;
      stage_pc_q    <= stage_pc_d;
      busy_q        <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs_q[wb_addr] <= wb_data;
    end
  end
endmodule

// File: tb/tb_ysyx_22041405_idu_pipe.sv
// tb/tb_ysyx_22041405_idu_pipe.sv - directed and randomized checks of ysyx_22041405_idu_pipe
module tb_ysyx_22041405_idu_pipe;
`ifdef YSYX_22041405_IDU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready, out_rd_wen, wb_en, flush;
  logic [31:0] in_inst, in_pc, out_inst, out_pc, out_rs1_data, out_rs2_data, out_imm, wb_data;
  logic [4:0]  out_rd, wb_addr;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_rd_wen, w_wb_en, w_flush;
  logic [31:0] w_in_inst, w_out_inst;
  logic [63:0] w_in_pc, w_out_pc, w_out_rs1_data, w_out_rs2_data, w_out_imm, w_wb_data;
  logic [3:0]  w_out_rd, w_wb_addr;

  always #5 clk = ~clk;

  ysyx_22041405_idu_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_rd(out_rd), .out_rd_wen(out_rd_wen), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush));

  ysyx_22041405_idu_pipe #(.WIDTH(64), .ADDR_WIDTH(4)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_inst(w_in_inst),
    .in_pc(w_in_pc), .out_valid(w_out_valid), .out_ready(w_out_ready), .out_inst(w_out_inst),
    .out_pc(w_out_pc), .out_rs1_data(w_out_rs1_data), .out_rs2_data(w_out_rs2_data),
    .out_imm(w_out_imm), .out_rd(w_out_rd), .out_rd_wen(w_out_rd_wen), .wb_en(w_wb_en),
    .wb_addr(w_wb_addr), .wb_data(w_wb_data), .flush(w_flush));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state: the architectural view of the stage
  bit          m_sv;
  logic [31:0] m_inst, m_pc;
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          f_in, f_out, f_wen;
  int          f_rd;

  function automatic void m_reset();
    m_sv = 0; m_inst = 0; m_pc = 0;
    for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_busy[i] = 0; end
  endfunction

  function automatic void decode(input logic [31:0] i, output int rs1, output int rs2,
                                 output int rd, output bit u1, output bit u2,
                                 output bit wen, output longint imm);
    int op;
    op  = int'(i[6:0]);
    rs1 = int'(i[19:15]) % 32;
    rs2 = int'(i[24:20]) % 32;
    rd  = int'(i[11:7]) % 32;
    u1  = !(op == 'h37 || op == 'h17 || op == 'h6f);
    u2  = (op == 'h33 || op == 'h23 || op == 'h63);
    wen = !(op == 'h23 || op == 'h63 || op == 'h0f) && rd != 0;
    case (op)
      'h13, 'h03, 'h67, 'h73: imm = longint'($signed(i[31:20]));
      'h23: imm = longint'($signed({i[31:25], i[11:7]}));
      'h63: imm = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      'h37, 'h17: imm = longint'($signed(i[31:12])) * 4096;
      'h6f: imm = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: imm = 0;
    endcase
  endfunction

  function automatic bit blocked(input int r);
    return m_busy[r] && !(BYP && wb_en && int'(wb_addr) == r);
  endfunction

  function automatic logic [31:0] rdval(input int r);
    if (r == 0) return 0;
    if (BYP && wb_en && int'(wb_addr) == r) return wb_data;
    return m_regs[r];
  endfunction

  task automatic settle();
    int rs1, rs2, rd;
    bit u1, u2, wen, hz, ov, ir;
    longint imm;
    #4;
    decode(m_inst, rs1, rs2, rd, u1, u2, wen, imm);
    hz = m_sv && ((u1 && blocked(rs1)) || (u2 && blocked(rs2)) || (wen && blocked(rd)));
    ov = m_sv && !hz && !flush;
    ir = !flush && (!m_sv || (ov && out_ready));
    check("m_out_valid", out_valid, ov);
    check("m_in_ready", in_ready, ir);
    check("m_out_inst", out_inst, m_inst);
    check("m_out_pc", out_pc, m_pc);
    check("m_out_imm", out_imm, imm[31:0]);
    check("m_out_rd", out_rd, rd);
    check("m_out_rd_wen", out_rd_wen, wen);
    check("m_rs1_data", out_rs1_data, rdval(rs1));
    check("m_rs2_data", out_rs2_data, rdval(rs2));
    f_in = in_valid && ir; f_out = ov && out_ready; f_wen = wen; f_rd = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    if (wb_en) m_busy[wb_addr] = 0;
    if (f_out && f_wen) m_busy[f_rd] = 1;
    m_busy[0] = 0;
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    if (flush) m_sv = 0;
    else if (f_in) begin m_sv = 1; m_inst = in_inst; m_pc = in_pc; end
    else if (f_out) m_sv = 0;
    #1;
  endtask

  task automatic idle();
    in_valid = 0; out_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1; in_inst = inst; in_pc = pc;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [12] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                             7'h23, 7'h13, 7'h33, 7'h0f, 7'h73, 7'h00};
    logic [31:0] x;
    x = $urandom;
    x[6:0]   = ops[$urandom_range(0, 11)];
    x[11:7]  = 5'($urandom_range(0, 7));
    x[19:15] = 5'($urandom_range(0, 7));
    x[24:20] = 5'($urandom_range(0, 7));
    return x;
  endfunction

  logic [31:0] s_inst, s_pc, s_imm, s_rs1, s_rs2;

  initial begin
    idle(); in_inst = 0; in_pc = 0;
    w_in_valid = 0; w_in_inst = 0; w_in_pc = 0; w_out_ready = 1;
    w_wb_en = 0; w_wb_addr = 0; w_wb_data = 0; w_flush = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_rd_wen", out_rd_wen, 0);
    check("rst_imm", out_imm, 0);
    check("rst_rs1", out_rs1_data, 0);
    rst = 1;

    offer(32'h00500093, 32'h80000000); settle(); tick();
    offer(32'h00108133, 32'h80000004); settle();
    check("addi_valid", out_valid, 1);
    check("addi_imm", out_imm, 5);
    check("addi_rd", out_rd, 1);
    check("addi_rd_wen", out_rd_wen, 1);
    check("addi_pc", out_pc, 32'h80000000);
    check("addi_accept_next", in_ready, 1);
    tick();
    idle(); settle();
    check("raw_stall_valid", out_valid, 0);
    check("raw_stall_ready", in_ready, 0);
    tick();
    out_ready = 0; wb_en = 1; wb_addr = 1; wb_data = 5; settle();
    check("wb_cycle_valid", out_valid, BYP);
    check("wb_cycle_rs1", out_rs1_data, BYP ? 32'd5 : 32'd0);
    tick();
    idle(); settle();
    check("after_wb_valid", out_valid, 1);
    check("after_wb_rs1", out_rs1_data, 5);
    check("after_wb_rs2", out_rs2_data, 5);
    tick();

    idle(); wb_en = 1; wb_addr = 2; wb_data = 10; out_ready = 0;
    offer(32'hFE20AE23, 32'h80000008); settle(); tick();
    idle(); out_ready = 0; settle();
    check("sw_valid", out_valid, 1);
    check("sw_imm", out_imm, 32'hFFFFFFFC);
    check("sw_rd_wen", out_rd_wen, 0);
    check("sw_in_ready", in_ready, 0);
    check("sw_rs2", out_rs2_data, 10);
    s_inst = out_inst; s_pc = out_pc; s_imm = out_imm; s_rs1 = out_rs1_data; s_rs2 = out_rs2_data;
    tick();
    for (int k = 0; k < 2; k++) begin
      settle();
      check("hold_inst", out_inst, s_inst);
      check("hold_pc", out_pc, s_pc);
      check("hold_imm", out_imm, s_imm);
      check("hold_rs1", out_rs1_data, s_rs1);
      check("hold_rs2", out_rs2_data, s_rs2);
      check("hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1; offer(32'h00700193, 32'h8000000C); settle();
    check("release_valid", out_valid, 1);
    check("release_in_ready", in_ready, 1);
    tick();

    offer(32'h00318233, 32'h80000010); settle(); tick();
    offer(32'h00100293, 32'h80000014); flush = 1; settle();
    check("flush_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 0);
    tick();
    idle(); settle();
    check("post_flush_valid", out_valid, 0);
    check("post_flush_ready", in_ready, 1);
    tick();
    offer(32'h00318233, 32'h80000018); settle(); tick();
    idle(); settle();
    check("busy_kept_valid", out_valid, 0);
    tick();
    out_ready = 0; wb_en = 1; wb_addr = 3; wb_data = 7; settle(); tick();
    idle(); settle();
    check("busy_cleared_valid", out_valid, 1);
    check("busy_cleared_rs1", out_rs1_data, 7);
    tick();

    for (int n = 0; n < 2000; n++) begin
      int cand [$];
      if (n == 1000) begin
        rst = 0; #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_ready", in_ready, 1);
        m_reset();
        #2; rst = 1;
      end
      idle();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = rand_inst();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      for (int r = 1; r < 32; r++) if (m_busy[r]) cand.push_back(r);
      if (cand.size() != 0 && $urandom_range(0, 1) == 1) begin
        wb_en = 1; wb_addr = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if ($urandom_range(0, 15) == 0) begin
        wb_en = 1; wb_addr = 0;
      end
      wb_data = $urandom;
      settle(); tick();
    end

    idle(); w_in_valid = 1; w_in_inst = 32'h800008B7; w_in_pc = 64'h80000000;
    settle();
    check("w64_in_ready", w_in_ready, 1);
    tick();
    w_in_valid = 0; settle();
    check("w64_valid", w_out_valid, 1);
    check("w64_rd", w_out_rd, 1);
    check("w64_rd_wen", w_out_rd_wen, 1);
    check("w64_imm", w_out_imm, 64'hFFFFFFFF80000000);
    check("w64_pc", w_out_pc, 64'h80000000);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
